// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC downstream of the branch comparator.
// Computes sequential/branch/JAL/JALR next PC, pulses redirect to fetch on
// taken transfers, and traps on illegal branch encodings or misaligned targets.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [1:0]  op_kind,
   input  logic [31:0] imm,
   input  logic [31:0] rs1,
   input  logic        taken,
   input  logic        br_error,
   output logic [31:0] pc,
   output logic [31:0] link,
   output logic        redirect,
   output logic        trap,
   output logic [3:0]  trap_cause,
   input  logic        trap_ack,
   output logic [15:0] taken_count
);

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned CAUSE_W = 4;

   localparam logic [1:0] K_SEQ  = 2'd0;
   localparam logic [1:0] K_BR   = 2'd1;
   localparam logic [1:0] K_JAL  = 2'd2;
   localparam logic [1:0] K_JALR = 2'd3;

   localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = CAUSE_W'(0);
   localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL  = CAUSE_W'(2);
   localparam logic [CNT_W-1:0]   CNT_MAX        = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_TRAP  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [31:0]          r_pc;
   logic [CAUSE_W-1:0]   r_trap_cause;
   logic [CNT_W-1:0]     r_taken_count;

   logic [31:0]          w_pc_plus4;
   logic [31:0]          w_pc_imm;
   logic [31:0]          w_rs1_imm;
   logic [31:0]          w_target;
   logic                 w_xfer;
   logic                 w_is_taken;
   logic                 w_br_err;
   logic                 w_misalign;

   // Candidate targets and outcome classification for the presented op
   always_comb begin
      w_pc_plus4 = r_pc + 32'd4;
      w_pc_imm   = r_pc + imm;
      w_rs1_imm  = rs1 + imm;
      w_target   = w_pc_plus4;
      w_is_taken = 1'b0;
      case (op_kind)
         K_SEQ: begin
            w_target   = w_pc_plus4;
            w_is_taken = 1'b0;
         end
         K_BR: begin
            w_target   = taken ? w_pc_imm : w_pc_plus4;
            w_is_taken = taken;
         end
         K_JAL: begin
            w_target   = w_pc_imm;
            w_is_taken = 1'b1;
         end
         K_JALR: begin
            w_target   = w_rs1_imm & ~32'h1;
            w_is_taken = 1'b1;
         end
         default: begin
            w_target   = w_pc_plus4;
            w_is_taken = 1'b0;
         end
      endcase
      w_xfer     = op_valid && (r_state == ST_RUN);
      w_br_err   = (op_kind == K_BR) && br_error;
      w_misalign = w_is_taken && (w_target[1:0] != 2'b00);
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_xfer) begin
               if (w_br_err || w_misalign) begin
                  w_next_state = ST_TRAP;
               end else if (w_is_taken) begin
                  w_next_state = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: w_next_state = ST_RUN;
         ST_TRAP: begin
            if (trap_ack) begin
               w_next_state = ST_FLUSH;
            end
         end
         default: w_next_state = ST_RUN;
      endcase
   end

   // Output decode from the registered state
   always_comb begin
      op_ready = 1'b0;
      redirect = 1'b0;
      trap     = 1'b0;
      case (r_state)
         ST_RUN:   op_ready = 1'b1;
         ST_FLUSH: redirect = 1'b1;
         ST_TRAP:  trap     = 1'b1;
         default:  op_ready = 1'b0;
      endcase
   end

   // PC, trap cause and saturating taken counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_trap_cause  <= CAUSE_W'(0);
         r_taken_count <= CNT_W'(0);
      end else begin
         if (w_xfer) begin
            if (w_br_err) begin
               r_trap_cause <= CAUSE_ILLEGAL;
            end else if (w_misalign) begin
               r_trap_cause <= CAUSE_MISALIGN;
            end else if (w_is_taken) begin
               r_pc <= w_target;
               if (r_taken_count != CNT_MAX) begin
                  r_taken_count <= r_taken_count + CNT_W'(1);
               end
            end else begin
               r_pc <= w_pc_plus4;
            end
         end else if ((r_state == ST_TRAP) && trap_ack) begin
            r_pc         <= TRAP_VECTOR;
            r_trap_cause <= CAUSE_W'(0);
         end
      end
   end

   assign pc          = r_pc;
   assign link        = w_pc_plus4;
   assign trap_cause  = r_trap_cause;
   assign taken_count = r_taken_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential flow, branches, JAL/JALR,
// traps and acknowledge, counter saturation and async reset out of TRAP.
`timescale 1ns/1ps
module tb_pc_sequencer;

   logic        clk;
   logic        reset;
   logic        op_valid;
   logic        op_ready;
   logic [1:0]  op_kind;
   logic [31:0] imm;
   logic [31:0] rs1;
   logic        taken;
   logic        br_error;
   logic [31:0] pc;
   logic [31:0] link;
   logic        redirect;
   logic        trap;
   logic [3:0]  trap_cause;
   logic        trap_ack;
   logic [15:0] taken_count;

   int n_total;
   int n_bad;

   pc_sequencer #(
      .RESET_PC    (32'h0000_0000),
      .TRAP_VECTOR (32'h0000_0100)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .op_kind     (op_kind),
      .imm         (imm),
      .rs1         (rs1),
      .taken       (taken),
      .br_error    (br_error),
      .pc          (pc),
      .link        (link),
      .redirect    (redirect),
      .trap        (trap),
      .trap_cause  (trap_cause),
      .trap_ack    (trap_ack),
      .taken_count (taken_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports mismatches
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
      end
   endtask

   // Present one op at the falling edge, let it be accepted, sample 1ns after the edge
   task automatic drive_op(input logic [1:0] k, input logic [31:0] im, input logic [31:0] r1,
                           input logic tk, input logic be);
      @(negedge clk);
      chk("ready_before_op", 32'(op_ready), 32'd1);
      op_kind  = k;
      imm      = im;
      rs1      = r1;
      taken    = tk;
      br_error = be;
      op_valid = 1'b1;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      taken    = 1'b0;
      br_error = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // After a taken transfer: check the flush cycle then the return to RUN
   task automatic chk_flush(input string tag, input logic [31:0] exp_pc, input logic [15:0] exp_cnt);
      chk({tag, "_pc"},       pc, exp_pc);
      chk({tag, "_redirect"}, 32'(redirect), 32'd1);
      chk({tag, "_ready0"},   32'(op_ready), 32'd0);
      chk({tag, "_cnt"},      32'(taken_count), 32'(exp_cnt));
      step();
      chk({tag, "_redir_end"}, 32'(redirect), 32'd0);
      chk({tag, "_ready1"},    32'(op_ready), 32'd1);
   endtask

   initial begin
      n_total  = 0;
      n_bad    = 0;
      reset    = 1'b1;
      op_valid = 1'b0;
      op_kind  = 2'd0;
      imm      = 32'd0;
      rs1      = 32'd0;
      taken    = 1'b0;
      br_error = 1'b0;
      trap_ack = 1'b0;

      #1;
      chk("rst_pc",    pc, 32'h0);
      chk("rst_redir", 32'(redirect), 32'd0);
      chk("rst_trap",  32'(trap), 32'd0);
      chk("rst_cause", 32'(trap_cause), 32'd0);
      chk("rst_cnt",   32'(taken_count), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      step();
      chk("run_pc0",   pc, 32'h0);
      chk("run_link0", link, 32'h4);

      // Sequential flow
      drive_op(2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("seq1_pc", pc, 32'h4);
      chk("seq1_redir", 32'(redirect), 32'd0);
      drive_op(2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("seq2_pc", pc, 32'h8);
      drive_op(2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("seq3_pc", pc, 32'hC);
      chk("seq3_link", link, 32'h10);
      chk("seq3_redir", 32'(redirect), 32'd0);
      chk("seq3_cnt", 32'(taken_count), 32'd0);

      // JAL to 0x40, then backward taken branch to 0x30
      drive_op(2'd2, 32'h34, 32'h0, 1'b0, 1'b0);
      chk_flush("jal40", 32'h40, 16'd1);
      drive_op(2'd1, 32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0);
      chk_flush("br_tk", 32'h30, 16'd2);

      // Back to 0x40, then branch not taken
      drive_op(2'd2, 32'h10, 32'h0, 1'b0, 1'b0);
      chk_flush("jal40b", 32'h40, 16'd3);
      drive_op(2'd1, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0);
      chk("br_nt_pc", pc, 32'h44);
      chk("br_nt_redir", 32'(redirect), 32'd0);
      chk("br_nt_ready", 32'(op_ready), 32'd1);
      chk("br_nt_cnt", 32'(taken_count), 32'd3);

      // JALR clears bit 0 of the target
      drive_op(2'd3, 32'h4, 32'h1001, 1'b0, 1'b0);
      chk_flush("jalr", 32'h1004, 16'd4);

      // JALR to a halfword-aligned target traps with cause 0
      drive_op(2'd3, 32'h0, 32'h1002, 1'b0, 1'b0);
      chk("mis_trap", 32'(trap), 32'd1);
      chk("mis_cause", 32'(trap_cause), 32'd0);
      chk("mis_pc", pc, 32'h1004);
      chk("mis_ready", 32'(op_ready), 32'd0);
      chk("mis_redir", 32'(redirect), 32'd0);
      chk("mis_cnt", 32'(taken_count), 32'd4);
      @(negedge clk);
      trap_ack = 1'b1;
      step();
      trap_ack = 1'b0;
      chk("ack1_trap", 32'(trap), 32'd0);
      chk_flush("ack1", 32'h100, 16'd4);

      // Misaligned offset on a not-taken branch does not trap
      drive_op(2'd1, 32'h2, 32'h0, 1'b0, 1'b0);
      chk("nt_mis_pc", pc, 32'h104);
      chk("nt_mis_trap", 32'(trap), 32'd0);

      // Illegal branch encoding wins over taken
      drive_op(2'd1, 32'h8, 32'h0, 1'b1, 1'b1);
      chk("ill_trap", 32'(trap), 32'd1);
      chk("ill_cause", 32'(trap_cause), 32'd2);
      chk("ill_pc", pc, 32'h104);
      chk("ill_cnt", 32'(taken_count), 32'd4);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("ill_hold_ready", 32'(op_ready), 32'd0);
         chk("ill_hold_cause", 32'(trap_cause), 32'd2);
         chk("ill_hold_pc", pc, 32'h104);
      end
      @(negedge clk);
      trap_ack = 1'b1;
      step();
      trap_ack = 1'b0;
      chk("ack2_trap", 32'(trap), 32'd0);
      chk("ack2_cause", 32'(trap_cause), 32'd0);
      chk_flush("ack2", 32'h100, 16'd4);

      // trap_ack in RUN is ignored
      @(negedge clk);
      trap_ack = 1'b1;
      step();
      trap_ack = 1'b0;
      chk("stray_ack_pc", pc, 32'h100);
      chk("stray_ack_redir", 32'(redirect), 32'd0);
      chk("stray_ack_ready", 32'(op_ready), 32'd1);

      // Counter saturation: preload near the top, then taken JALs
      @(negedge clk);
      force dut.r_taken_count = 16'hFFFD;
      @(negedge clk);
      release dut.r_taken_count;
      #1;
      chk("preload_cnt", 32'(taken_count), 32'h0000_FFFD);
      drive_op(2'd2, 32'h8, 32'h0, 1'b0, 1'b0);
      chk_flush("sat1", 32'h108, 16'hFFFE);
      drive_op(2'd2, 32'h8, 32'h0, 1'b0, 1'b0);
      chk_flush("sat2", 32'h110, 16'hFFFF);
      drive_op(2'd2, 32'h8, 32'h0, 1'b0, 1'b0);
      chk_flush("sat3", 32'h118, 16'hFFFF);

      // Enter TRAP via misaligned JAL, then reset mid-cycle
      drive_op(2'd2, 32'h2, 32'h0, 1'b0, 1'b0);
      chk("pre_rst_trap", 32'(trap), 32'd1);
      chk("pre_rst_cnt", 32'(taken_count), 32'h0000_FFFF);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_trap", 32'(trap), 32'd0);
      chk("arst_redir", 32'(redirect), 32'd0);
      chk("arst_cnt", 32'(taken_count), 32'd0);
      chk("arst_pc", pc, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      step();
      chk("post_rst_ready", 32'(op_ready), 32'd1);
      chk("post_rst_pc", pc, 32'h0);
      drive_op(2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("post_rst_seq", pc, 32'h4);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
